// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back sequencer and its queue.
package wb_pkg;

  localparam int DW   = 32;
  localparam int RA_W = 4;
  localparam logic [RA_W-1:0] PC_ADDR = 4'hF;

  typedef struct packed {
    logic            dual;
    logic [RA_W-1:0] a1;
    logic [DW-1:0]   d1;
    logic [RA_W-1:0] a2;
    logic [DW-1:0]   d2;
  } wb_entry_t;

  // A queued entry blocks decode on reg if either of its live destinations
  // matches; the PC is never reported because it has its own write path.
  function automatic logic entry_hits(input wb_entry_t e, input logic [RA_W-1:0] reg_addr);
    return (reg_addr != PC_ADDR) &&
           ((e.a1 == reg_addr) || (e.dual && (e.a2 == reg_addr)));
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of write-back entries exposing head, per-slot valid bits
// and the whole entry array so the parent can scan it for hazards.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  wb_entry_t             wr_entry,
  output wb_entry_t             head,
  output logic [DEPTH-1:0]      valid,
  output wb_entry_t [DEPTH-1:0] entries,
  output logic                  empty,
  output logic                  full,
  output logic [CW-1:0]         count
);

  wb_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DEPTH-1:0]      valid_next;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];
  assign entries = mem;

  // Clear before set: when full, push and pop hit the same slot and the new entry must stay valid.
  always_comb begin
    valid_next = valid;
    if (do_pop)
      valid_next[rd_ptr] = 1'b0;
    if (do_push)
      valid_next[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      valid <= valid_next;
      if (do_push)
        wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/wb_sequencer.sv
// Write-back sequencer: queues single/dual-destination results and retires one
// per enabled cycle onto register file ports 3/4 and the PC write path.
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_dual,
  input  logic [RA_W-1:0]        req_a1,
  input  logic [DW-1:0]          req_d1,
  input  logic [RA_W-1:0]        req_a2,
  input  logic [DW-1:0]          req_d2,
  input  logic                   wb_en,
  output logic                   we3,
  output logic [RA_W-1:0]        wa3,
  output logic [DW-1:0]          wd3,
  output logic                   we4,
  output logic [RA_W-1:0]        wa4,
  output logic [DW-1:0]          wd4,
  output logic                   pc_we,
  output logic [DW-1:0]          pc_wd,
  input  logic [RA_W-1:0]        chk_a1,
  input  logic [RA_W-1:0]        chk_a2,
  output logic                   hazard,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  wb_entry_t             head;
  wb_entry_t             wr_entry;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  same_dst;
  logic                  a2_is_pc;

  assign pop       = wb_en & ~empty;
  assign req_ready = ~full | pop;
  assign push      = req_valid & req_ready;

  assign wr_entry = '{dual: req_dual, a1: req_a1, d1: req_d1, a2: req_a2, d2: req_d2};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .head     (head),
    .valid    (valid),
    .entries  (entries),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );

  // For a dual write to the same register port 4 carries it, so the second destination wins.
  always_comb begin
    we3      = 1'b0;
    wa3      = '0;
    wd3      = '0;
    we4      = 1'b0;
    wa4      = '0;
    wd4      = '0;
    pc_we    = 1'b0;
    pc_wd    = '0;
    same_dst = 1'b0;
    a2_is_pc = 1'b0;
    if (pop) begin
      same_dst = head.dual && (head.a1 == head.a2);
      a2_is_pc = head.dual && (head.a2 == PC_ADDR);
      we3      = (head.a1 != PC_ADDR) && !same_dst;
      wa3      = head.a1;
      wd3      = head.d1;
      we4      = head.dual && (head.a2 != PC_ADDR);
      wa4      = head.a2;
      wd4      = head.d2;
      pc_we    = (head.a1 == PC_ADDR) || a2_is_pc;
      pc_wd    = a2_is_pc ? head.d2 : head.d1;
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entry_hits(entries[i], chk_a1) || entry_hits(entries[i], chk_a2)))
        hazard = 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: directed vector table, reset-mid-operation sequence,
// then random traffic against a queue-based reference model.
module tb_wb_sequencer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic        valid;
    logic        dual;
    logic [3:0]  a1;
    logic [31:0] d1;
    logic [3:0]  a2;
    logic [31:0] d2;
    logic        wb_en;
    logic [3:0]  chk_a1;
    logic [3:0]  chk_a2;
  } stim_t;

  typedef struct packed {
    logic        we3;
    logic [3:0]  wa3;
    logic [31:0] wd3;
    logic        we4;
    logic [3:0]  wa4;
    logic [31:0] wd4;
    logic        pc_we;
    logic [31:0] pc_wd;
    logic        ready;
    logic        hazard;
    logic [2:0]  count;
  } want_t;

  typedef struct packed {
    stim_t stim;
    want_t want;
  } vec_t;

  typedef struct packed {
    logic        dual;
    logic [3:0]  a1;
    logic [31:0] d1;
    logic [3:0]  a2;
    logic [31:0] d2;
  } ment_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_dual;
  logic [3:0]  req_a1;
  logic [31:0] req_d1;
  logic [3:0]  req_a2;
  logic [31:0] req_d2;
  logic        wb_en;
  logic        we3;
  logic [3:0]  wa3;
  logic [31:0] wd3;
  logic        we4;
  logic [3:0]  wa4;
  logic [31:0] wd4;
  logic        pc_we;
  logic [31:0] pc_wd;
  logic [3:0]  chk_a1;
  logic [3:0]  chk_a2;
  logic        hazard;
  logic        empty;
  logic [2:0]  count;

  int pass_cnt = 0;
  int total_cnt = 0;

  ment_t model_q[$];
  vec_t  vecs[18];

  always #5 clk = ~clk;

  wb_sequencer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dual  (req_dual),
    .req_a1    (req_a1),
    .req_d1    (req_d1),
    .req_a2    (req_a2),
    .req_d2    (req_d2),
    .wb_en     (wb_en),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .we4       (we4),
    .wa4       (wa4),
    .wd4       (wd4),
    .pc_we     (pc_we),
    .pc_wd     (pc_wd),
    .chk_a1    (chk_a1),
    .chk_a2    (chk_a2),
    .hazard    (hazard),
    .empty     (empty),
    .count     (count)
  );

  function automatic stim_t mk_stim(logic v, logic du, logic [3:0] a1, logic [31:0] d1,
                                    logic [3:0] a2, logic [31:0] d2, logic en,
                                    logic [3:0] c1, logic [3:0] c2);
    stim_t s;
    s = '{valid: v, dual: du, a1: a1, d1: d1, a2: a2, d2: d2, wb_en: en, chk_a1: c1, chk_a2: c2};
    return s;
  endfunction

  function automatic want_t mk_want(logic e3, logic [3:0] a3, logic [31:0] d3,
                                    logic e4, logic [3:0] a4, logic [31:0] d4,
                                    logic pe, logic [31:0] pd, logic rdy, logic hz,
                                    logic [2:0] cnt);
    want_t w;
    w = '{we3: e3, wa3: a3, wd3: d3, we4: e4, wa4: a4, wd4: d4, pc_we: pe, pc_wd: pd,
          ready: rdy, hazard: hz, count: cnt};
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp)
      pass_cnt++;
    else
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input stim_t s);
    req_valid = s.valid;
    req_dual  = s.dual;
    req_a1    = s.a1;
    req_d1    = s.d1;
    req_a2    = s.a2;
    req_d2    = s.d2;
    wb_en     = s.wb_en;
    chk_a1    = s.chk_a1;
    chk_a2    = s.chk_a2;
  endtask

  // Addresses/data are only meaningful while the matching enable is set.
  task automatic checkOutput(input want_t w, input string tag);
    check({tag, ".we3"}, 32'(we3), 32'(w.we3));
    check({tag, ".we4"}, 32'(we4), 32'(w.we4));
    check({tag, ".pc_we"}, 32'(pc_we), 32'(w.pc_we));
    check({tag, ".req_ready"}, 32'(req_ready), 32'(w.ready));
    check({tag, ".hazard"}, 32'(hazard), 32'(w.hazard));
    check({tag, ".count"}, 32'(count), 32'(w.count));
    check({tag, ".empty"}, 32'(empty), 32'(w.count == 3'd0));
    if (w.we3) begin
      check({tag, ".wa3"}, 32'(wa3), 32'(w.wa3));
      check({tag, ".wd3"}, wd3, w.wd3);
    end
    if (w.we4) begin
      check({tag, ".wa4"}, 32'(wa4), 32'(w.wa4));
      check({tag, ".wd4"}, wd4, w.wd4);
    end
    if (w.pc_we)
      check({tag, ".pc_wd"}, pc_wd, w.pc_wd);
  endtask

  function automatic logic model_hit(input ment_t m, input logic [3:0] r);
    if (r == 4'd15)
      return 1'b0;
    return (m.a1 == r) || (m.dual && m.a2 == r);
  endfunction

  function automatic want_t model_expect(input stim_t s);
    want_t w;
    ment_t h;
    logic  pop_now;
    w       = '0;
    pop_now = s.wb_en && (model_q.size() > 0);
    if (pop_now) begin
      h       = model_q[0];
      w.pc_we = (h.a1 == 4'd15) || (h.dual && h.a2 == 4'd15);
      w.pc_wd = (h.dual && h.a2 == 4'd15) ? h.d2 : h.d1;
      w.we3   = (h.a1 != 4'd15) && !(h.dual && h.a1 == h.a2);
      w.wa3   = h.a1;
      w.wd3   = h.d1;
      w.we4   = h.dual && (h.a2 != 4'd15);
      w.wa4   = h.a2;
      w.wd4   = h.d2;
    end
    w.ready = (model_q.size() < DEPTH) || pop_now;
    w.count = 3'(model_q.size());
    foreach (model_q[k])
      if (model_hit(model_q[k], s.chk_a1) || model_hit(model_q[k], s.chk_a2))
        w.hazard = 1'b1;
    return w;
  endfunction

  task automatic run_model_cycle(input stim_t s, input string tag);
    want_t w;
    ment_t m;
    @(negedge clk);
    applyStimulus(s);
    #1;
    w = model_expect(s);
    checkOutput(w, tag);
    if (s.wb_en && model_q.size() > 0)
      void'(model_q.pop_front());
    if (s.valid && w.ready) begin
      m = '{dual: s.dual, a1: s.a1, d1: s.d1, a2: s.a2, d2: s.d2};
      model_q.push_back(m);
    end
  endtask

  initial begin
    stim_t s;

    // Hand-derived cycle-by-cycle expectations; count/hazard reflect the queue before each edge.
    vecs[0]  = '{mk_stim(1,0, 3,'h11,  0,0,    1, 0,0),  mk_want(0,0,0,     0,0,0,     0,0,      1,0,0)};
    vecs[1]  = '{mk_stim(0,0, 0,0,     0,0,    1, 3,0),  mk_want(1,3,'h11,  0,0,0,     0,0,      1,1,1)};
    vecs[2]  = '{mk_stim(1,1, 2,'hA,   5,'hB,  1, 3,0),  mk_want(0,0,0,     0,0,0,     0,0,      1,0,0)};
    vecs[3]  = '{mk_stim(1,1, 15,'h100,7,'h5,  1, 0,0),  mk_want(1,2,'hA,   1,5,'hB,   0,0,      1,0,1)};
    vecs[4]  = '{mk_stim(1,1, 4,'h21,  4,'h22, 1, 7,0),  mk_want(0,0,0,     1,7,'h5,   1,'h100,  1,1,1)};
    vecs[5]  = '{mk_stim(0,0, 0,0,     0,0,    1, 4,0),  mk_want(0,0,0,     1,4,'h22,  0,0,      1,1,1)};
    vecs[6]  = '{mk_stim(1,0, 6,'h66,  0,0,    0, 6,0),  mk_want(0,0,0,     0,0,0,     0,0,      1,0,0)};
    vecs[7]  = '{mk_stim(1,0, 15,'h77, 0,0,    0, 6,15), mk_want(0,0,0,     0,0,0,     0,0,      1,1,1)};
    vecs[8]  = '{mk_stim(0,0, 0,0,     0,0,    0, 0,15), mk_want(0,0,0,     0,0,0,     0,0,      1,0,2)};
    vecs[9]  = '{mk_stim(1,0, 8,'h88,  0,0,    0, 6,0),  mk_want(0,0,0,     0,0,0,     0,0,      1,1,2)};
    vecs[10] = '{mk_stim(1,0, 9,'h99,  0,0,    0, 0,0),  mk_want(0,0,0,     0,0,0,     0,0,      1,0,3)};
    vecs[11] = '{mk_stim(1,0, 10,'hAA, 0,0,    0, 6,0),  mk_want(0,0,0,     0,0,0,     0,0,      0,1,4)};
    vecs[12] = '{mk_stim(1,0, 10,'hAA, 0,0,    1, 6,0),  mk_want(1,6,'h66,  0,0,0,     0,0,      1,1,4)};
    vecs[13] = '{mk_stim(0,0, 0,0,     0,0,    1, 6,0),  mk_want(0,0,0,     0,0,0,     1,'h77,   1,0,4)};
    vecs[14] = '{mk_stim(0,0, 0,0,     0,0,    1, 6,0),  mk_want(1,8,'h88,  0,0,0,     0,0,      1,0,3)};
    vecs[15] = '{mk_stim(0,0, 0,0,     0,0,    1, 6,0),  mk_want(1,9,'h99,  0,0,0,     0,0,      1,0,2)};
    vecs[16] = '{mk_stim(0,0, 0,0,     0,0,    1, 6,0),  mk_want(1,10,'hAA, 0,0,0,     0,0,      1,0,1)};
    vecs[17] = '{mk_stim(0,0, 0,0,     0,0,    1, 6,0),  mk_want(0,0,0,     0,0,0,     0,0,      1,0,0)};

    reset = 1'b1;
    applyStimulus(mk_stim(0,0,0,0,0,0,1,0,0));
    repeat (2) @(negedge clk);
    #1;
    checkOutput(mk_want(0,0,0,0,0,0,0,0,1,0,0), "reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].stim);
      #1;
      checkOutput(vecs[i].want, $sformatf("vec%0d", i));
    end

    // Three entries queued, then reset lands between edges with wb_en high.
    model_q.delete();
    run_model_cycle(mk_stim(1,0, 1,'h1001, 0,0,      0, 0,0), "pre0");
    run_model_cycle(mk_stim(1,1, 2,'h1002, 3,'h2003, 0, 0,0), "pre1");
    run_model_cycle(mk_stim(1,0, 5,'h1005, 0,0,      0, 0,0), "pre2");
    run_model_cycle(mk_stim(0,0, 0,0,      0,0,      0, 1,3), "pre3");
    @(negedge clk);
    applyStimulus(mk_stim(0,0,0,0,0,0,1,1,3));
    reset = 1'b1;
    #1;
    checkOutput(mk_want(0,0,0,0,0,0,0,0,1,0,0), "rst_mid");
    @(negedge clk);
    #1;
    checkOutput(mk_want(0,0,0,0,0,0,0,0,1,0,0), "rst_hold");
    reset = 1'b0;
    model_q.delete();

    for (int i = 0; i < 400; i++) begin
      s.valid  = ($urandom_range(0, 9) < 7);
      s.dual   = 1'($urandom_range(0, 1));
      s.a1     = 4'($urandom_range(0, 15));
      s.a2     = ($urandom_range(0, 3) == 0) ? s.a1 : 4'($urandom_range(0, 15));
      s.d1     = $urandom();
      s.d2     = $urandom();
      s.wb_en  = ($urandom_range(0, 9) < 5);
      s.chk_a1 = 4'($urandom_range(0, 15));
      s.chk_a2 = 4'($urandom_range(0, 15));
      run_model_cycle(s, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
